// File: rtl/me_pkg.sv
// Shared constants, pixel type and feeder state encoding for the ME pixel feeder.
package me_pkg;
   localparam int unsigned MACRO_DIM  = 16;
   localparam int unsigned SEARCH_DIM = 48;
   localparam int unsigned PORT_WIDTH = MACRO_DIM + 1;

   localparam int unsigned COL_W = $clog2(SEARCH_DIM);
   localparam int unsigned SA_W  = $clog2(SEARCH_DIM * SEARCH_DIM);
   localparam int unsigned CA_W  = $clog2(MACRO_DIM * MACRO_DIM);

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } feeder_state_t;
endpackage

// File: rtl/me_pixel_feeder_if.sv
// Loader/ME-core side bus of the pixel feeder: buffer writes, stream request and column output.
interface me_pixel_feeder_if #(
   parameter  int unsigned MACRO_DIM  = me_pkg::MACRO_DIM,
   parameter  int unsigned SEARCH_DIM = me_pkg::SEARCH_DIM,
   localparam int unsigned PORT_WIDTH = MACRO_DIM + 1,
   localparam int unsigned COL_W      = $clog2(SEARCH_DIM),
   localparam int unsigned SA_W       = $clog2(SEARCH_DIM * SEARCH_DIM)
);
   import me_pkg::*;

   logic                      wr_en;
   logic                      wr_sel;
   logic [SA_W-1:0]           wr_addr;
   pixel_t                    wr_data;
   logic                      en_ram;
   logic [COL_W-1:0]          row_base;
   logic                      stall;
   logic                      busy;
   pixel_t [PORT_WIDTH-1:0]   pixel_spr_out;
   pixel_t [MACRO_DIM-1:0]    pixel_cpr_out;
   logic                      col_valid;
   logic [COL_W-1:0]          col_idx;
   logic                      col_last;
   logic                      req_drop;
   logic                      wr_drop;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, en_ram, row_base, stall,
      input  busy, pixel_spr_out, pixel_cpr_out, col_valid, col_idx, col_last, req_drop, wr_drop
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, en_ram, row_base, stall,
      output busy, pixel_spr_out, pixel_cpr_out, col_valid, col_idx, col_last, req_drop, wr_drop
   );
endinterface

// File: rtl/me_pixel_buf.sv
// Search-window and current-macroblock storage with one write port and a registered
// column read (PORT_WIDTH search lanes + MACRO_DIM current lanes, zero outside the window).
module me_pixel_buf #(
   parameter  int unsigned MACRO_DIM  = me_pkg::MACRO_DIM,
   parameter  int unsigned SEARCH_DIM = me_pkg::SEARCH_DIM,
   localparam int unsigned PORT_WIDTH = MACRO_DIM + 1,
   localparam int unsigned COL_W      = $clog2(SEARCH_DIM),
   localparam int unsigned SA_W       = $clog2(SEARCH_DIM * SEARCH_DIM),
   localparam int unsigned CA_W       = $clog2(MACRO_DIM * MACRO_DIM)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             wr_en_i,
   input  logic                             wr_sel_i,
   input  logic [SA_W-1:0]                  wr_addr_i,
   input  me_pkg::pixel_t                   wr_data_i,
   input  logic                             rd_en_i,
   input  logic [COL_W-1:0]                 rd_row_base_i,
   input  logic [COL_W-1:0]                 rd_col_i,
   output me_pkg::pixel_t [PORT_WIDTH-1:0]  spr_o,
   output me_pkg::pixel_t [MACRO_DIM-1:0]   cpr_o
);
   import me_pkg::*;

   pixel_t search_q [SEARCH_DIM*SEARCH_DIM];
   pixel_t curr_q   [MACRO_DIM*MACRO_DIM];

   pixel_t [PORT_WIDTH-1:0] spr_q, spr_d;
   pixel_t [MACRO_DIM-1:0]  cpr_q, cpr_d;

   // Buffer write; contents survive reset, range checking is done by the caller.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         if (wr_sel_i) curr_q[wr_addr_i[CA_W-1:0]] <= wr_data_i;
         else          search_q[wr_addr_i]         <= wr_data_i;
      end
   end

   // Column gather: rows past the window bottom and columns past the macroblock read as 0.
   always_comb begin
      spr_d = '0;
      cpr_d = '0;
      for (int unsigned k = 0; k < PORT_WIDTH; k++) begin
         if (32'(rd_row_base_i) + k < SEARCH_DIM)
            spr_d[k] = search_q[SA_W'((32'(rd_row_base_i) + k) * SEARCH_DIM + 32'(rd_col_i))];
      end
      if (32'(rd_col_i) < MACRO_DIM) begin
         for (int unsigned j = 0; j < MACRO_DIM; j++)
            cpr_d[j] = curr_q[CA_W'(j * MACRO_DIM + 32'(rd_col_i))];
      end
   end

   // Output lane register: loads on read enable, otherwise holds the last column.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         spr_q <= '0;
         cpr_q <= '0;
      end else if (rd_en_i) begin
         spr_q <= spr_d;
         cpr_q <= cpr_d;
      end
   end

   assign spr_o = spr_q;
   assign cpr_o = cpr_q;
endmodule

// File: rtl/me_pixel_feeder.sv
// Motion-estimation pixel feeder: buffers one search window and one macroblock and
// streams one column per accepted cycle on en_ram, with stall hold and drop pulses.
module me_pixel_feeder #(
   parameter  int unsigned MACRO_DIM  = me_pkg::MACRO_DIM,
   parameter  int unsigned SEARCH_DIM = me_pkg::SEARCH_DIM,
   localparam int unsigned COL_W      = $clog2(SEARCH_DIM)
) (
   input logic               clk,
   input logic               rst,
   me_pixel_feeder_if.slave  bus
);
   import me_pkg::*;

   feeder_state_t    state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [COL_W-1:0] row_base_q, row_base_d;
   logic [COL_W-1:0] col_idx_q, col_idx_d;
   logic             col_valid_q, col_valid_d;
   logic             col_last_q, col_last_d;
   logic             busy_q, req_drop_q, wr_drop_q;
   logic             rd_en;
   logic [COL_W-1:0] rd_row_base, rd_col;
   logic             wr_in_range, wr_accept;

   assign wr_in_range = bus.wr_sel ? (32'(bus.wr_addr) < MACRO_DIM * MACRO_DIM)
                                   : (32'(bus.wr_addr) < SEARCH_DIM * SEARCH_DIM);
   assign wr_accept   = bus.wr_en & (state_q == IDLE) & wr_in_range & ~rst;

   // Next-state and column sequencing. Column 0 is read at the en_ram edge itself
   // (row_base taken straight from the port) so it appears one cycle after the request;
   // col_q therefore always holds the next column to fetch.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_base_d  = row_base_q;
      col_idx_d   = col_idx_q;
      col_valid_d = col_valid_q;
      col_last_d  = col_last_q;
      rd_en       = 1'b0;
      rd_col      = col_q;
      rd_row_base = row_base_q;
      unique case (state_q)
         IDLE: begin
            if (bus.en_ram) begin
               state_d     = STREAM;
               row_base_d  = bus.row_base;
               rd_en       = 1'b1;
               rd_col      = '0;
               rd_row_base = bus.row_base;
               col_idx_d   = '0;
               col_valid_d = 1'b1;
               col_last_d  = 1'b0;
               col_d       = COL_W'(1);
            end
         end
         STREAM: begin
            if (!bus.stall) begin
               rd_en     = 1'b1;
               col_idx_d = col_q;
               col_d     = col_q + COL_W'(1);
               if (col_q == COL_W'(SEARCH_DIM - 1)) begin
                  col_last_d = 1'b1;
                  state_d    = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (!bus.stall) begin
               state_d     = IDLE;
               col_valid_d = 1'b0;
               col_last_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, handshake outputs and one-cycle drop pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_base_q  <= '0;
         col_idx_q   <= '0;
         col_valid_q <= 1'b0;
         col_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         req_drop_q  <= 1'b0;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_base_q  <= row_base_d;
         col_idx_q   <= col_idx_d;
         col_valid_q <= col_valid_d;
         col_last_q  <= col_last_d;
         busy_q      <= (state_d != IDLE);
         req_drop_q  <= bus.en_ram & (state_q != IDLE);
         wr_drop_q   <= bus.wr_en & ~wr_accept;
      end
   end

   me_pixel_buf #(
      .MACRO_DIM  (MACRO_DIM),
      .SEARCH_DIM (SEARCH_DIM)
   ) u_buf (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_en_i       (wr_accept),
      .wr_sel_i      (bus.wr_sel),
      .wr_addr_i     (bus.wr_addr),
      .wr_data_i     (bus.wr_data),
      .rd_en_i       (rd_en),
      .rd_row_base_i (rd_row_base),
      .rd_col_i      (rd_col),
      .spr_o         (bus.pixel_spr_out),
      .cpr_o         (bus.pixel_cpr_out)
   );

   assign bus.busy      = busy_q;
   assign bus.col_valid = col_valid_q;
   assign bus.col_idx   = col_idx_q;
   assign bus.col_last  = col_last_q;
   assign bus.req_drop  = req_drop_q;
   assign bus.wr_drop   = wr_drop_q;
endmodule

// File: doc/me_pixel_feeder.md
Name: me_pixel_feeder

Overview:
- Source side of the motion-estimation pixel interface. Holds one search window and one current macroblock.
- On the ME core's en_ram request, streams search-window columns (PORT_WIDTH = MACRO_DIM+1 rows tall) and current-macroblock columns, one column per cycle.
- Sits between the frame-buffer loader and the `me` core. It replaces the behavioural pixel driver used in ME simulation.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels
- SEARCH_DIM, 48, search-window edge in pixels
- PORT_WIDTH, MACRO_DIM+1, search column height per cycle (derived, not overridable)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = search buffer, 1 = current buffer
- wr_addr  in  $clog2(SEARCH_DIM*SEARCH_DIM)  raster address, row*DIM+col
- wr_data  in  8  pixel
- en_ram  in  1  stream request from ME core
- row_base  in  $clog2(SEARCH_DIM)  first search row of the band; sampled with en_ram
- stall  in  1  consumer not accepting the current column
- busy  out  1  stream in progress
- pixel_spr_out  out  8 x PORT_WIDTH  search column; element k = search[(row_base+k)*SEARCH_DIM+col]
- pixel_cpr_out  out  8 x MACRO_DIM  current column; element j = curr[j*MACRO_DIM+col]
- col_valid  out  1  column outputs valid
- col_idx  out  $clog2(SEARCH_DIM)  column index of presented data
- col_last  out  1  presented column is SEARCH_DIM-1
- req_drop  out  1  one-cycle pulse: en_ram ignored
- wr_drop  out  1  one-cycle pulse: write ignored

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0, including every pixel lane. Buffer contents are not cleared.
- Writes:
  - Accepted in IDLE only. Takes effect at the clock edge.
  - wr_sel=1 with wr_addr >= MACRO_DIM*MACRO_DIM is dropped and pulses wr_drop.
  - wr_en while busy is dropped and pulses wr_drop the next cycle.
- States: IDLE, STREAM, FLUSH.
- IDLE -> STREAM when en_ram=1 at an edge: latch row_base, col counter=0, busy=1 from the next cycle.
- STREAM:
  - Each edge with stall=0 registers column col onto the outputs: col_valid=1, col_idx=col. Then col++.
  - First column is visible the cycle after en_ram is sampled (1-cycle latency).
  - When col=SEARCH_DIM-1 is registered, col_last=1 and the state goes to FLUSH.
- stall=1 while col_valid=1: outputs, col_idx and col_last hold unchanged and the counter does not advance. Consumer takes a column on any cycle with col_valid & !stall.
- FLUSH: hold the last column until taken (stall=0). Next cycle: col_valid=0, col_last=0, busy=0, back to IDLE. Pixel lanes keep their last values.
- Boundary rows: lane k with row_base+k >= SEARCH_DIM outputs 0.
- Current lanes: pixel_cpr_out is valid for col < MACRO_DIM. It is driven 0 for col >= MACRO_DIM.
- en_ram with busy=1 (STREAM or FLUSH): ignored; req_drop pulses the next cycle; the stream is unaffected.
- en_ram and the FLUSH exit in the same cycle: dropped. The ME core must re-request.
- Reset mid-stream: immediate return to IDLE with reset output values. No partial column is emitted after reset.
- No arithmetic beyond the counter and row_base+k. Compute at $clog2(SEARCH_DIM)+1 bits to avoid wrap; there is no wrap-around of row addressing.

Decomposition:
- Package me_pkg:
  - constants MACRO_DIM, SEARCH_DIM, PORT_WIDTH
  - pixel_t (logic [7:0])
  - feeder_state_t enum {IDLE, STREAM, FLUSH}
  - address-width localparams
- One sub-module, me_pixel_buf:
  - search storage organised as PORT_WIDTH-readable columns (flop array or SEARCH_DIM row banks)
  - current-block storage
  - single write port
  - registered column read of PORT_WIDTH + MACRO_DIM lanes, zero-filled out of range
- The top holds the FSM, counter, handshake and drop pulses.

Test Plan:
- Reset values: assert rst with random inputs -> busy=0, col_valid=0, col_last=0, all lanes 0. Deassert mid-cycle -> stays IDLE.
- Full stream:
  - Load search[r*48+c]=(r+c)&8'hFF and curr[j*16+c]=8'h80+j+c. Pulse en_ram with row_base=0, stall=0.
  - Next cycle: col_idx=0, spr[k]=k, cpr[j]=8'h80+j.
  - 48 consecutive valid cycles; col 47 has spr[0]=47 and col_last=1; cpr lanes are 0 from col 16.
  - busy drops one cycle after the last column.
- Bottom boundary: row_base=40, col 5 -> spr[k]=45+k for k=0..7, spr[8..16]=0.
- Stall:
  - Assert stall for 3 cycles at col_idx=10 -> outputs frozen at col 10 for 4 cycles; next column is 11; total accepted columns remain 48.
  - Stall at col 47 -> FLUSH holds until released.
- Drops:
  - en_ram at col 20 -> req_drop pulse, stream continues to 47 unaltered.
  - wr_en during STREAM -> wr_drop pulse; a later read shows old data.
  - Current-buffer write at address 256 -> wr_drop pulse.
- Reset mid-stream: rst at col 30 -> all outputs 0 the same cycle. A new en_ram after release restarts at col 0 with the buffer contents intact.
